// File: rtl/pipelined_dot_mac_pe_if.sv
// pipelined_dot_mac_pe_if: operand, valid and partial-sum bundle for one systolic dot-product PE
interface pipelined_dot_mac_pe_if #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int NumInputs    = 4
);
  logic [NumInputs-1:0][InDataWidth-1:0] a_i, b_i, a_east_o, b_south_o;
  logic a_valid_i, b_valid_i, a_valid_o, b_valid_o, acc_valid_o, ovf_o;
  logic [1:0] acc_mux_sel_i;
  logic [OutDataWidth-1:0] acc_north_i, acc_west_i, acc_east_o, acc_south_o;
  modport master (
    output a_i, b_i, a_valid_i, b_valid_i, acc_mux_sel_i, acc_north_i, acc_west_i,
    input  a_east_o, b_south_o, a_valid_o, b_valid_o, acc_east_o, acc_south_o, acc_valid_o, ovf_o
  );
  modport slave (
    input  a_i, b_i, a_valid_i, b_valid_i, acc_mux_sel_i, acc_north_i, acc_west_i,
    output a_east_o, b_south_o, a_valid_o, b_valid_o, acc_east_o, acc_south_o, acc_valid_o, ovf_o
  );
endinterface

// File: rtl/pipelined_dot_mac_pe.sv
// pipelined_dot_mac_pe: systolic PE, NumInputs-lane signed dot product into a chained accumulator.
// Define MAC_PE_SATURATE_EN for saturating accumulation with a sticky ovf_o flag.
module pipelined_dot_mac_pe #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int NumInputs     = 4,
  parameter int MulPipeStages = 1
) (
  input logic clk_i,
  input logic rst_i,
  pipelined_dot_mac_pe_if.slave bus
);
  if (MulPipeStages < 0 || MulPipeStages > 3) begin : g_bad_stages
    $error("MulPipeStages must be 0..3");
  end
  if (OutDataWidth < 2*InDataWidth + $clog2(NumInputs)) begin : g_bad_width
    $error("OutDataWidth too narrow for the dot product");
  end
  logic fire, clr, dv, upd;
  logic [1:0] sel;
  logic signed [OutDataWidth-1:0] dot, dot_p, acc, base, addend, sum, acc_nx;
  assign sel  = bus.acc_mux_sel_i;
  assign fire = bus.a_valid_i & bus.b_valid_i;
  assign clr  = sel == 2'b11;
  always_comb begin : p_dot
    logic signed [2*InDataWidth-1:0] prod;
    dot  = '0;
    prod = '0;
    for (int i = 0; i < NumInputs; i++) begin
      prod = $signed({{InDataWidth{bus.a_i[i][InDataWidth-1]}}, bus.a_i[i]})
           * $signed({{InDataWidth{bus.b_i[i][InDataWidth-1]}}, bus.b_i[i]});
      dot  = dot + OutDataWidth'(prod);
    end
  end
  if (MulPipeStages == 0) begin : g_comb
    assign dot_p = dot;
    assign dv    = fire;
  end else begin : g_pipe
    logic [MulPipeStages-1:0][OutDataWidth-1:0] pd;
    logic [MulPipeStages-1:0] pv;
    // a clear flushes every in-flight beat, including the one firing this edge
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pd <= '0;
        pv <= '0;
      end else begin
        for (int s = MulPipeStages-1; s > 0; s--) begin
          pd[s] <= pd[s-1];
          pv[s] <= pv[s-1] & ~clr;
        end
        pd[0] <= dot;
        pv[0] <= fire & ~clr;
      end
    end
    assign dot_p = pd[MulPipeStages-1];
    assign dv    = pv[MulPipeStages-1];
  end
  assign base   = sel == 2'b01 ? bus.acc_north_i : sel == 2'b10 ? bus.acc_west_i : acc;
  assign addend = dv ? dot_p : '0;
  assign upd    = dv | (sel != 2'b00);
`ifdef MAC_PE_SATURATE_EN
  logic signed [OutDataWidth:0] wide;
  logic sat, ovf;
  assign wide = {base[OutDataWidth-1], base} + {addend[OutDataWidth-1], addend};
  assign sat  = wide[OutDataWidth] != wide[OutDataWidth-1];
  assign sum  = sat ? {wide[OutDataWidth], {(OutDataWidth-1){~wide[OutDataWidth]}}} : wide[OutDataWidth-1:0];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf <= 1'b0;
    else ovf <= clr ? 1'b0 : ovf | sat;
  end
  assign bus.ovf_o = ovf;
`else
  assign sum       = base + addend;
  assign bus.ovf_o = 1'b0;
`endif
  assign acc_nx = clr ? '0 : upd ? sum : acc;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.a_east_o    <= '0;
      bus.b_south_o   <= '0;
      bus.a_valid_o   <= 1'b0;
      bus.b_valid_o   <= 1'b0;
      bus.acc_valid_o <= 1'b0;
      acc             <= '0;
    end else begin
      if (bus.a_valid_i) bus.a_east_o <= bus.a_i;
      if (bus.b_valid_i) bus.b_south_o <= bus.b_i;
      bus.a_valid_o   <= bus.a_valid_i;
      bus.b_valid_o   <= bus.b_valid_i;
      bus.acc_valid_o <= upd;
      acc             <= acc_nx;
    end
  end
  assign bus.acc_east_o  = acc;
  assign bus.acc_south_o = acc;
endmodule

// File: tb/tb_pipelined_dot_mac_pe.sv
// tb_pipelined_dot_mac_pe: directed and random stimulus checked against a queue-based behavioural model.
module tb_pipelined_dot_mac_pe;
  localparam int W = 8, OW = 32, N = 4, S = 1;
  localparam longint MAXV = (64'sd1 <<< (OW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OW-1));
  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {int dot; int due;} beat_t;
  logic clk_i = 1'b0, rst_i = 1'b1, run = 1'b0;
  int total = 0, bad = 0;
  pipelined_dot_mac_pe_if #(.InDataWidth(W), .OutDataWidth(OW), .NumInputs(N)) bus();
  pipelined_dot_mac_pe #(.InDataWidth(W), .OutDataWidth(OW), .NumInputs(N), .MulPipeStages(S)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic vec_t splat(logic [W-1:0] x);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = x;
    return v;
  endfunction
  function automatic int dot_of(vec_t a, vec_t b);
    int s = 0;
    for (int i = 0; i < N; i++) s += $signed(a[i]) * $signed(b[i]);
    return s;
  endfunction
  // model: fired beats wait in a queue until their due edge; a clear empties the queue
  beat_t q[$];
  vec_t m_a = '0, m_b = '0;
  logic m_av = 0, m_bv = 0, m_accv = 0, m_ovf = 0, m_dv;
  logic [OW-1:0] m_acc = '0;
  int cyc = 0, m_d;
  longint m_r, m_base;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_a = '0; m_b = '0; m_av = 0; m_bv = 0; m_accv = 0; m_ovf = 0; m_acc = '0;
      q.delete();
      cyc = 0;
    end else begin
      cyc++;
      if (bus.a_valid_i) m_a = bus.a_i;
      if (bus.b_valid_i) m_b = bus.b_i;
      m_av = bus.a_valid_i;
      m_bv = bus.b_valid_i;
      if (bus.a_valid_i && bus.b_valid_i) q.push_back('{dot_of(bus.a_i, bus.b_i), cyc + S});
      m_dv = 0;
      m_d = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_dv = 1;
        m_d = q[0].dot;
        void'(q.pop_front());
      end
      m_accv = m_dv || bus.acc_mux_sel_i != 2'b00;
      if (bus.acc_mux_sel_i == 2'b11) begin
        m_acc = '0;
        m_ovf = 0;
        q.delete();
      end else if (m_accv) begin
        case (bus.acc_mux_sel_i)
          2'b01:   m_base = longint'($signed(bus.acc_north_i));
          2'b10:   m_base = longint'($signed(bus.acc_west_i));
          default: m_base = longint'($signed(m_acc));
        endcase
        m_r = m_base + (m_dv ? longint'(m_d) : 64'sd0);
`ifdef MAC_PE_SATURATE_EN
        if (m_r > MAXV) begin m_r = MAXV; m_ovf = 1; end
        else if (m_r < MINV) begin m_r = MINV; m_ovf = 1; end
`endif
        m_acc = m_r[OW-1:0];
      end
    end
  end
  always @(negedge clk_i) if (run) begin
    chk("a_east", bus.a_east_o, m_a);
    chk("b_south", bus.b_south_o, m_b);
    chk("a_valid", bus.a_valid_o, m_av);
    chk("b_valid", bus.b_valid_o, m_bv);
    chk("acc_east", bus.acc_east_o, m_acc);
    chk("acc_south", bus.acc_south_o, m_acc);
    chk("acc_valid", bus.acc_valid_o, m_accv);
    chk("ovf", bus.ovf_o, m_ovf);
  end
  task automatic drive(vec_t a, vec_t b, logic av, logic bv, logic [1:0] sel);
    bus.a_i = a; bus.b_i = b; bus.a_valid_i = av; bus.b_valid_i = bv; bus.acc_mux_sel_i = sel;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic idle(logic [1:0] sel);
    drive('0, '0, 0, 0, sel);
  endtask
  initial begin
    bus.a_i = '0; bus.b_i = '0; bus.a_valid_i = 0; bus.b_valid_i = 0;
    bus.acc_mux_sel_i = 2'b00; bus.acc_north_i = '0; bus.acc_west_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_acc", bus.acc_east_o, 0);
    chk("rst_a_east", bus.a_east_o, 0);
    chk("rst_accv", bus.acc_valid_o, 0);
    rst_i = 0;
    run = 1;
    drive(splat(8'hFF), splat(8'd10), 1, 1, 2'b00);
    chk("t1_a_east", bus.a_east_o, 32'hFFFF_FFFF);
    chk("t1_a_valid", bus.a_valid_o, 1);
    chk("t1_accv_early", bus.acc_valid_o, 0);
    idle(2'b00);
    chk("t1_acc_east", bus.acc_east_o, 32'hFFFF_FFD8);
    chk("t1_acc_south", bus.acc_south_o, 32'hFFFF_FFD8);
    chk("t1_accv", bus.acc_valid_o, 1);
    idle(2'b11);
    drive(splat(8'd2), splat(8'd3), 1, 1, 2'b00);
    drive(splat(8'd2), splat(8'd3), 1, 1, 2'b00);
    chk("t2_acc24", bus.acc_east_o, 24);
    drive(splat(8'd2), splat(8'd3), 1, 1, 2'b00);
    chk("t2_acc48", bus.acc_east_o, 48);
    idle(2'b00);
    chk("t2_acc72", bus.acc_east_o, 72);
    idle(2'b00);
    chk("t2_hold72", bus.acc_east_o, 72);
    chk("t2_accv_low", bus.acc_valid_o, 0);
    bus.acc_north_i = 32'd1234;
    idle(2'b01);
    chk("t3_north", bus.acc_east_o, 1234);
    drive(splat(8'd2), splat(8'd3), 1, 1, 2'b00);
    bus.acc_west_i = 32'hFFFF_FFFB;
    idle(2'b10);
    chk("t3_west", bus.acc_east_o, 19);
    drive(splat(8'd1), splat(8'd1), 1, 1, 2'b00);
    idle(2'b11);
    chk("t4_clear", bus.acc_east_o, 0);
    idle(2'b00);
    idle(2'b00);
    chk("t4_flushed", bus.acc_east_o, 0);
    chk("t4_ovf", bus.ovf_o, 0);
    drive(splat(8'd7), splat(8'd9), 1, 0, 2'b00);
    chk("t5_a_east", bus.a_east_o, 32'h0707_0707);
    chk("t5_b_hold", bus.b_south_o, 32'h0101_0101);
    chk("t5_acc", bus.acc_east_o, 0);
    chk("t5_accv", bus.acc_valid_o, 0);
    drive(splat(8'd5), splat(8'd5), 1, 1, 2'b00);
    bus.a_valid_i = 0; bus.b_valid_i = 0;
    #1 rst_i = 1;
    #1;
    chk("t5_rst_acc", bus.acc_east_o, 0);
    chk("t5_rst_a_east", bus.a_east_o, 0);
    chk("t5_rst_avalid", bus.a_valid_o, 0);
    chk("t5_rst_accv", bus.acc_valid_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    idle(2'b00);
    idle(2'b00);
    chk("t5_no_update", bus.acc_east_o, 0);
    bus.acc_north_i = 32'h7FFF_FFF0;
    idle(2'b01);
    chk("t6_load", bus.acc_east_o, 32'h7FFF_FFF0);
    drive(splat(8'd127), splat(8'd127), 1, 1, 2'b00);
    idle(2'b00);
`ifdef MAC_PE_SATURATE_EN
    chk("t6_sat", bus.acc_east_o, 32'h7FFF_FFFF);
    chk("t6_ovf", bus.ovf_o, 1);
    idle(2'b00);
    chk("t6_ovf_sticky", bus.ovf_o, 1);
`else
    chk("t6_wrap", bus.acc_east_o, 32'h8000_FBF4);
    chk("t6_ovf", bus.ovf_o, 0);
    idle(2'b00);
`endif
    idle(2'b11);
    chk("t6_clear_ovf", bus.ovf_o, 0);
    for (int k = 0; k < 600; k++) begin
      automatic int r = $urandom_range(0, 15);
      bus.acc_north_i = $urandom;
      bus.acc_west_i = $urandom;
      drive($urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            r == 15 ? 2'b11 : r == 14 ? 2'b10 : r >= 12 ? 2'b01 : 2'b00);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
